// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note divisors, ROM entry
// layout, FSM state encoding and the default demo phrase.
package melody_pkg;

  // ROM entry layout: {div[19:0], beats[3:0]}.
  localparam int DIV_W     = 20;
  localparam int BEATS_W   = 4;
  localparam int ENTRY_W   = DIV_W + BEATS_W;

  // The beat counter is never narrower than this. The top widens it further
  // when 15 * BEAT_DIV needs more bits.
  localparam int CNT_MIN_W = 24 + BEATS_W;

  // Note divisors: clk cycles per tone period at a 25 MHz crystal.
  localparam logic [DIV_W-1:0] REST    = 20'd0;
  localparam logic [DIV_W-1:0] NOTE_C4 = 20'd95556;
  localparam logic [DIV_W-1:0] NOTE_D4 = 20'd85131;
  localparam logic [DIV_W-1:0] NOTE_E4 = 20'd75843;
  localparam logic [DIV_W-1:0] NOTE_F4 = 20'd71586;
  localparam logic [DIV_W-1:0] NOTE_G4 = 20'd63776;
  localparam logic [DIV_W-1:0] NOTE_A4 = 20'd56818;
  localparam logic [DIV_W-1:0] NOTE_B4 = 20'd50619;
  localparam logic [DIV_W-1:0] NOTE_C5 = 20'd47778;
  localparam logic [DIV_W-1:0] NOTE_D5 = 20'd42566;
  localparam logic [DIV_W-1:0] NOTE_E5 = 20'd37922;
  localparam logic [DIV_W-1:0] NOTE_F5 = 20'd35793;
  localparam logic [DIV_W-1:0] NOTE_G5 = 20'd31888;
  localparam logic [DIV_W-1:0] NOTE_A5 = 20'd28409;
  localparam logic [DIV_W-1:0] NOTE_B5 = 20'd25310;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_GAP    = 3'd3,
    ST_PAUSED = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Four-entry phrase, entry 0 in the low bits. It is repeated to fill the
  // default ROM, which therefore ends by the implicit end-of-ROM rule.
  localparam logic [4*ENTRY_W-1:0] DEMO_PHRASE =
    {NOTE_C5, 4'd4, NOTE_G4, 4'd2, NOTE_E4, 4'd2, NOTE_C4, 4'd2};

  function automatic logic [DIV_W-1:0] entry_div(input logic [ENTRY_W-1:0] entry);
    return entry[ENTRY_W-1:BEATS_W];
  endfunction

  function automatic logic [BEATS_W-1:0] entry_beats(input logic [ENTRY_W-1:0] entry);
    return entry[BEATS_W-1:0];
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Song ROM: SONG_LEN entries of ENTRY_W bits. The read is registered, so
// data appears one clock after the address. Entry i sits at
// SONG_INIT[i*ENTRY_W +: ENTRY_W]. SONG_LEN must be a power of two, >= 4.
module melody_rom
  import melody_pkg::*;
#(
  parameter int SONG_LEN = 32,
  parameter logic [SONG_LEN*ENTRY_W-1:0] SONG_INIT = {(SONG_LEN/4){DEMO_PHRASE}},
  localparam int ADDR_W = $clog2(SONG_LEN)
) (
  input  logic               clk,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [ENTRY_W-1:0] data_o
);

  logic [ENTRY_W-1:0] rom_mem [SONG_LEN];
  logic [ENTRY_W-1:0] data_q;

  for (genvar i = 0; i < SONG_LEN; i++) begin : g_rom
    assign rom_mem[i] = SONG_INIT[i*ENTRY_W +: ENTRY_W];
  end

  // Registered ROM read.
  always_ff @(posedge clk) begin
    data_q <= rom_mem[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a song ROM and drives a note generator.
// Each entry plays for beats*BEAT_DIV - GAP_CYCLES cycles. A muted
// articulation gap of GAP_CYCLES cycles follows each entry.
// Define MELODY_LOOP_EN to restart from entry 0 at the end of the song
// instead of returning to IDLE.
//
// Control pulses: play, pause and stop are single-cycle strobes sampled on
// every rising clk edge. There is no handshake. A pulse that has no meaning
// in the current state is dropped. When pulses coincide, stop beats pause
// and pause beats play.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_DIV   = 25_000_000,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int SONG_LEN   = 32,
  parameter logic [SONG_LEN*ENTRY_W-1:0] SONG_INIT = {(SONG_LEN/4){DEMO_PHRASE}},
  localparam int IDX_W = $clog2(SONG_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             play,
  input  logic             pause,
  input  logic             stop,
  output logic [DIV_W-1:0] note_div,
  output logic             mute,
  output logic             busy,
  output logic             song_done,
  output logic [IDX_W-1:0] step_idx,
  output logic [2:0]       dbg_state
);

  localparam int PLAY_MAX = 15 * BEAT_DIV;
  localparam int CNT_W    = ($clog2(PLAY_MAX + 1) > CNT_MIN_W) ? $clog2(PLAY_MAX + 1) : CNT_MIN_W;

  localparam logic [CNT_W-1:0] BEAT_DIV_C = CNT_W'(BEAT_DIV);
  localparam logic [CNT_W-1:0] PLAY_ADJ   = CNT_W'(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SONG_LEN - 1);

  state_e             state_q, state_d;
  state_e             ret_q, ret_d;       // state to resume into after PAUSED
  logic               fetch_q, fetch_d;   // 0: address cycle, 1: data cycle
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // cycles left in PLAY/GAP, minus one
  logic [IDX_W-1:0]   step_q, step_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               mute_q, mute_d;
  logic               mute_sv_q, mute_sv_d; // mute to restore on resume

  logic [ENTRY_W-1:0] rom_data;
  logic [DIV_W-1:0]   rom_div;
  logic [BEATS_W-1:0] rom_beats;
  logic [CNT_W-1:0]   play_last;

  melody_rom #(
    .SONG_LEN  (SONG_LEN),
    .SONG_INIT (SONG_INIT)
  ) u_rom (
    .clk    (clk),
    .addr_i (step_q),
    .data_o (rom_data)
  );

  assign rom_div   = entry_div(rom_data);
  assign rom_beats = entry_beats(rom_data);
  assign play_last = {{(CNT_W-BEATS_W){1'b0}}, rom_beats} * BEAT_DIV_C - PLAY_ADJ;

  // Next state. The normal step is computed first. A pause then diverts that
  // step into PAUSED and records it as the resume target. A stop overrides
  // everything. The cycle that carries the pause still counts as played.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    fetch_d   = fetch_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    div_d     = div_q;
    mute_d    = mute_q;
    mute_sv_d = mute_sv_q;

    case (state_q)
      ST_IDLE: begin
        if (play) begin
          state_d = ST_FETCH;
          step_d  = '0;
          fetch_d = 1'b0;
        end
      end
      ST_FETCH: begin
        if (!fetch_q) begin
          fetch_d = 1'b1;
        end else begin
          fetch_d = 1'b0;
          if (rom_beats == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_PLAY;
            div_d   = rom_div;
            mute_d  = (rom_div == REST);
            cnt_d   = play_last;
          end
        end
      end
      ST_PLAY: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          mute_d  = 1'b1;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          if (step_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
            step_d  = step_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_PAUSED: begin
        if (play) begin
          state_d = ret_q;
          mute_d  = mute_sv_q;
        end
      end
      ST_DONE: begin
`ifdef MELODY_LOOP_EN
        state_d = ST_FETCH;
`else
        state_d = ST_IDLE;
        div_d   = '0;
`endif
        step_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pause && (state_q == ST_PLAY || state_q == ST_GAP)) begin
      ret_d     = state_d;
      mute_sv_d = mute_d;
      state_d   = ST_PAUSED;
      mute_d    = 1'b1;
    end

    if (stop) begin
      state_d = ST_IDLE;
      fetch_d = 1'b0;
      cnt_d   = '0;
      step_d  = '0;
      div_d   = '0;
      mute_d  = 1'b1;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      fetch_q   <= 1'b0;
      cnt_q     <= '0;
      step_q    <= '0;
      div_q     <= '0;
      mute_q    <= 1'b1;
      mute_sv_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      fetch_q   <= fetch_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      div_q     <= div_d;
      mute_q    <= mute_d;
      mute_sv_q <= mute_sv_d;
    end
  end

  assign note_div  = div_q;
  assign mute      = mute_q;
  assign busy      = (state_q != ST_IDLE);
  assign song_done = (state_q == ST_DONE);
  assign step_idx  = step_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer. Two instances share the control pulses: one
// has a song with an end marker, the other has none. The reference model
// expands a song into its cycle-by-cycle output timeline from the
// beats/gap rules. It then edits that timeline for pause, stop and reset.
module tb_melody_sequencer;
  import melody_pkg::*;

  localparam int BD    = 10;
  localparam int GAP   = 2;
  localparam int LEN   = 4;
  localparam int IDX_W = 2;
  localparam int VEC_W = DIV_W + 3 + IDX_W;   // {note_div, mute, busy, song_done, step_idx}

  localparam int PH_IDLE   = 0;
  localparam int PH_BUSY   = 1;   // FETCH / DONE: pause is ignored
  localparam int PH_PLAY   = 2;
  localparam int PH_GAP    = 3;
  localparam int PH_PAUSED = 4;

  // Entry 0 in the low bits.
  localparam logic [LEN*ENTRY_W-1:0] SONG_A =
    {NOTE_D5, 4'd0, NOTE_G4, 4'd1, REST, 4'd1, NOTE_C4, 4'd2};
  localparam logic [LEN*ENTRY_W-1:0] SONG_B =
    {NOTE_A4, 4'd1, REST, 4'd1, NOTE_E4, 4'd1, NOTE_C5, 4'd2};

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n, play, pause, stop, sel;

  logic [DIV_W-1:0] div_a, div_b;
  logic             mute_a, mute_b, busy_a, busy_b, done_a, done_b;
  logic [IDX_W-1:0] idx_a, idx_b;
  logic [2:0]       dbg_a, dbg_b;

  always #5 clk = ~clk;

  melody_sequencer #(.BEAT_DIV(BD), .GAP_CYCLES(GAP), .SONG_LEN(LEN), .SONG_INIT(SONG_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .play(play), .pause(pause), .stop(stop),
    .note_div(div_a), .mute(mute_a), .busy(busy_a), .song_done(done_a),
    .step_idx(idx_a), .dbg_state(dbg_a)
  );

  melody_sequencer #(.BEAT_DIV(BD), .GAP_CYCLES(GAP), .SONG_LEN(LEN), .SONG_INIT(SONG_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .play(play), .pause(pause), .stop(stop),
    .note_div(div_b), .mute(mute_b), .busy(busy_b), .song_done(done_b),
    .step_idx(idx_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int               n_vec = 0;
  int               n_err = 0;
  logic [VEC_W-1:0] exp_q[$];
  int               ph_q[$];
  logic [VEC_W-1:0] cur_exp;
  int               cur_ph;
  logic [DIV_W-1:0] m_div;

  function automatic logic [VEC_W-1:0] mk(input logic [DIV_W-1:0] d, input logic m, b, sd,
                                          input int st);
    logic [IDX_W-1:0] s;
    s = IDX_W'(st);
    return {d, m, b, sd, s};
  endfunction

  function automatic logic [VEC_W-1:0] observed();
    if (sel) return {div_b, mute_b, busy_b, done_b, idx_b};
    return {div_a, mute_a, busy_a, done_a, idx_a};
  endfunction

  function automatic logic [ENTRY_W-1:0] song_entry(input logic s, input int i);
    logic [LEN*ENTRY_W-1:0] img;
    img = s ? SONG_B : SONG_A;
    return img[i*ENTRY_W +: ENTRY_W];
  endfunction

  task automatic check_vec(input string tag, input logic [VEC_W-1:0] got,
                           input logic [VEC_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got div=%0d mute=%0b busy=%0b done=%0b idx=%0d | exp div=%0d mute=%0b busy=%0b done=%0b idx=%0d (state=%0d)",
               tag, $time,
               got[VEC_W-1 -: DIV_W], got[IDX_W+2], got[IDX_W+1], got[IDX_W], got[IDX_W-1:0],
               exp[VEC_W-1 -: DIV_W], exp[IDX_W+2], exp[IDX_W+1], exp[IDX_W], exp[IDX_W-1:0],
               sel ? dbg_b : dbg_a);
    end
  endtask

  task automatic push(input logic [VEC_W-1:0] v, input int ph);
    exp_q.push_back(v);
    ph_q.push_back(ph);
  endtask

  // Expand the selected song into its uninterrupted output timeline.
  task automatic gen_song();
    logic [ENTRY_W-1:0] e;
    logic [DIV_W-1:0]   d;
    int                 bt;
    for (int i = 0; i < LEN; i++) begin
      e  = song_entry(sel, i);
      d  = e[ENTRY_W-1:BEATS_W];
      bt = int'(e[BEATS_W-1:0]);
      push(mk(m_div, 1'b1, 1'b1, 1'b0, i), PH_BUSY);
      push(mk(m_div, 1'b1, 1'b1, 1'b0, i), PH_BUSY);
      if (bt == 0) begin
        push(mk(m_div, 1'b1, 1'b1, 1'b1, i), PH_BUSY);
        return;
      end
      m_div = d;
      repeat (bt * BD - GAP) push(mk(d, (d == '0), 1'b1, 1'b0, i), PH_PLAY);
      repeat (GAP) push(mk(d, 1'b1, 1'b1, 1'b0, i), PH_GAP);
    end
    push(mk(m_div, 1'b1, 1'b1, 1'b1, LEN - 1), PH_BUSY);
  endtask

  task automatic take_next();
    cur_exp = exp_q.pop_front();
    cur_ph  = ph_q.pop_front();
  endtask

  task automatic go_idle();
    exp_q.delete();
    ph_q.delete();
    m_div   = '0;
    cur_exp = mk('0, 1'b1, 1'b0, 1'b0, 0);
    cur_ph  = PH_IDLE;
  endtask

  // Model response to the pulses sampled at the coming clock edge.
  task automatic advance(input logic p_rst, p_play, p_pause, p_stop);
    logic [VEC_W-1:0] f;
    if (p_rst || p_stop) begin
      go_idle();
    end else if (cur_ph == PH_PAUSED) begin
      if (p_play) take_next();
    end else if ((cur_ph == PH_PLAY || cur_ph == PH_GAP) && p_pause) begin
      f       = exp_q[0];
      cur_exp = {f[VEC_W-1 -: DIV_W], 1'b1, 1'b1, 1'b0, f[IDX_W-1:0]};
      cur_ph  = PH_PAUSED;
    end else if (cur_ph == PH_IDLE) begin
      if (p_play) begin
        gen_song();
        take_next();
      end
    end else if (exp_q.size() == 0) begin
`ifdef MELODY_LOOP_EN
      gen_song();
      take_next();
`else
      go_idle();
`endif
    end else begin
      take_next();
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: check, drive, then wait one cycle.
  task automatic step_cycle(input string tag, input logic p_rst, p_play, p_pause, p_stop);
    check_vec(tag, observed(), cur_exp);
    rst_n = !p_rst;
    play  = p_play;
    pause = p_pause;
    stop  = p_stop;
    advance(p_rst, p_play, p_pause, p_stop);
    @(negedge clk);
    rst_n = 1'b1;
    play  = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic run_to_idle(input string tag);
    int budget;
    budget = exp_q.size() + 2;
    for (int k = 0; k < budget && cur_ph != PH_IDLE; k++) step_cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MELODY_LOOP_EN
    step_cycle({tag, "_stop"}, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
  endtask

  task automatic run_random(input string tag, input int n);
    for (int k = 0; k < n; k++)
      step_cycle(tag, 1'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 23) == 0),
                 ($urandom_range(0, 199) == 0));
    step_cycle({tag, "_end"}, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; sel = 1'b0;
    m_div   = '0;
    cur_exp = mk('0, 1'b1, 1'b0, 1'b0, 0);
    cur_ph  = PH_IDLE;
    @(negedge clk);

    repeat (2) step_cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    step_cycle("idle_pause", 1'b0, 1'b0, 1'b1, 1'b0);
    step_cycle("idle_stop",  1'b0, 1'b0, 1'b0, 1'b1);
    step_cycle("idle",       1'b0, 1'b0, 1'b0, 1'b0);

    // Whole song with end marker.
    step_cycle("start", 1'b0, 1'b1, 1'b0, 1'b0);
    run_to_idle("song");

    // Pause on the 5th PLAY cycle, 20 paused cycles, then resume.
    step_cycle("start_p", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (6) step_cycle("pre_pause", 1'b0, 1'b0, 1'b0, 1'b0);
    step_cycle("pause", 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 19; k++) step_cycle("paused", 1'b0, 1'b0, (k == 7), 1'b0);
    step_cycle("resume", 1'b0, 1'b1, 1'b0, 1'b0);
    run_to_idle("after_resume");

    // Stop and pause together in the first GAP; stray plays are ignored.
    step_cycle("start_s", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 40 && cur_ph != PH_GAP; k++)
      step_cycle("to_gap", 1'b0, ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
    step_cycle("stop_pause", 1'b0, 1'b0, 1'b1, 1'b1);
    step_cycle("after_stop", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-PLAY, then play on the first cycle after reset.
    step_cycle("start_r", 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) step_cycle("mid_play", 1'b0, 1'b0, 1'b0, 1'b0);
    step_cycle("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0);
    step_cycle("play_after_rst", 1'b0, 1'b1, 1'b0, 1'b0);
    run_to_idle("song_after_rst");

    run_random("random_a", 800);

    // Switch to the song without an end marker.
    step_cycle("to_b", 1'b1, 1'b0, 1'b0, 1'b0);
    sel = 1'b1;
    step_cycle("start_b", 1'b0, 1'b1, 1'b0, 1'b0);
    run_to_idle("song_b");
    run_random("random_b", 800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
